// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: stage-register states and inter-stage payload structs.
// Payload structs are cast to the stage DATA_W at instantiation.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pstage_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } ifid_t;

    function automatic logic [1:0] pstage_occ(input pstage_state_t s);
        case (s)
            PS_ONE:  return 2'd1;
            PS_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter for performance monitoring; clear beats increment.
// Latency: count reflects inc/clr one cycle later; no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register with optional 2-entry skid, flush and stall counter.
// Latency 1 cycle; with skid, in_ready depends on state only (no path from out_ready).
module pipe_stage
    import cpu_types_pkg::*;
#(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0,
    parameter bit                FLUSH_ZERO = 1'b1,
    parameter bit                SKID_EN    = 1'b1,
    parameter int                CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    pstage_state_t     state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state != PS_EMPTY);
    assign in_ready  = SKID_EN ? ((state != PS_FULL) && !RST)
                               : ((!out_valid || out_ready) && !RST);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = main_q;
    assign occupancy = pstage_occ(state);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= PS_EMPTY;
            main_q <= RESET_VAL;
        end else if (flush) begin
            state <= PS_EMPTY;
            if (FLUSH_ZERO) main_q <= RESET_VAL;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_data;
                        state  <= PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire && SKID_EN) begin
                        state <= PS_FULL;
                    end else if (out_fire) begin
                        state <= PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= PS_ONE;
                    end
                end
                default: state <= PS_EMPTY;
            endcase
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            // Skid only captures when the main entry cannot drain this cycle.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    skid_q <= RESET_VAL;
                end else if (flush) begin
                    if (FLUSH_ZERO) skid_q <= RESET_VAL;
                end else if ((state == PS_ONE) && in_fire && !out_fire) begin
                    skid_q <= in_data;
                end
            end
        end else begin : g_noskid
            assign skid_q = RESET_VAL;
        end
    endgenerate

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (out_valid && !out_ready && !flush),
        .clr   (stall_clr),
        .count (stall_cnt)
    );

endmodule
